// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU op codes, forwarding selects,
// funct3 codes, EX-stage FSM states and the EX/MEM control payload.
package riscv_pkg;

    // ID_EX_alu_op encoding
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_MUL   = 2'b11;

    // forward_a / forward_b encoding (2'b11 aliases FWD_ID_EX)
    localparam logic [1:0] FWD_ID_EX  = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_WB     = 2'b10;

    // funct3 codes for the register/immediate ALU group
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ex_state_e;

    // Control bits carried from ID/EX into EX/MEM
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b,
// retiring MUL_BITS multiplier bits per cycle.
//   start  : capture a/b, clear accumulator (ignored while busy)
//   busy   : iteration in progress
//   done_c : the current cycle performs the final iteration
//   product: accumulator, final once busy has dropped
module iter_mul #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done_c,
    output logic [XLEN-1:0] product
);

    localparam int unsigned MUL_CYC = XLEN / MUL_BITS;
    localparam int unsigned CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [XLEN-1:0]  partial;

    // mcand * mplier[MUL_BITS-1:0] as a sum of shifted multiplicands
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    // Next-state for the iteration registers
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start && !busy_q) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done_c  = busy_q && (cnt_q == CNT_LAST);
    assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU decode/compute, iterative MUL sequencing
// and the EX/MEM pipeline register.
//   ID_EX_*   : decoded instruction from the ID/EX register
//   forward_* : operand source selects from the forwarding unit
//   wb_data   : MEM/WB writeback value for forwarding
//   alu_out   : combinational non-MUL result (ID-stage branch forwarding)
//   ex_busy   : combinational stall request while a MUL is in flight
//   EX_MEM_*  : registered EX/MEM outputs
module execute_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] ID_EX_data1,
    input  logic [XLEN-1:0] ID_EX_data2,
    input  logic [XLEN-1:0] ID_EX_imm_gen,
    input  logic [4:0]      ID_EX_rd,
    input  logic [3:0]      ID_EX_inst_func,
    input  logic [1:0]      ID_EX_alu_op,
    input  logic            ID_EX_alu_src,
    input  logic            ID_EX_mem_read,
    input  logic            ID_EX_mem_write,
    input  logic            ID_EX_mem_to_reg,
    input  logic            ID_EX_reg_write,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_out,
    output logic            ex_busy,
    output logic [XLEN-1:0] EX_MEM_alu_out,
    output logic [XLEN-1:0] EX_MEM_write_data,
    output logic [4:0]      EX_MEM_rd,
    output logic            EX_MEM_mem_read,
    output logic            EX_MEM_mem_write,
    output logic            EX_MEM_mem_to_reg,
    output logic            EX_MEM_reg_write
);

    ex_state_e       state_q, state_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    ex_mem_ctrl_t    ctrl_q, ctrl_d;
    ex_mem_ctrl_t    id_ctrl;

    logic [XLEN-1:0] op_a, fwd_b, op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            mul_start_c;
    logic            mul_busy;
    logic            mul_done_c;
    logic [XLEN-1:0] mul_product;

    assign id_ctrl = '{mem_read:   ID_EX_mem_read,
                       mem_write:  ID_EX_mem_write,
                       mem_to_reg: ID_EX_mem_to_reg,
                       reg_write:  ID_EX_reg_write};

    // Forwarding muxes; select 2'b11 falls back to the ID/EX value
    always_comb begin
        case (forward_a)
            FWD_EX_MEM: op_a = alu_out_q;
            FWD_WB:     op_a = wb_data;
            default:    op_a = ID_EX_data1;
        endcase
        case (forward_b)
            FWD_EX_MEM: fwd_b = alu_out_q;
            FWD_WB:     fwd_b = wb_data;
            default:    fwd_b = ID_EX_data2;
        endcase
        op_b  = ID_EX_alu_src ? ID_EX_imm_gen : fwd_b;
        shamt = op_b[4:0];
    end

    // ALU decode; inst_func[3] is inst[30] (sub / arithmetic shift)
    always_comb begin
        alu_res = op_a + op_b;
        case (ID_EX_alu_op)
            ALU_OP_SUB: alu_res = op_a - op_b;
            ALU_OP_FUNCT: begin
                case (ID_EX_inst_func[2:0])
                    F3_ADD:  alu_res = (ID_EX_inst_func[3] && !ID_EX_alu_src) ? (op_a - op_b)
                                                                              : (op_a + op_b);
                    F3_SLL:  alu_res = op_a << shamt;
                    F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
                    F3_XOR:  alu_res = op_a ^ op_b;
                    F3_SR:   alu_res = ID_EX_inst_func[3] ? XLEN'($signed(op_a) >>> shamt)
                                                          : (op_a >> shamt);
                    F3_OR:   alu_res = op_a | op_b;
                    default: alu_res = op_a & op_b;
                endcase
            end
            default: alu_res = op_a + op_b;
        endcase
    end

    assign mul_start_c = (state_q == IDLE) && (ID_EX_alu_op == ALU_OP_MUL);
    assign ex_busy     = mul_start_c || (state_q == RUN);
    assign alu_out     = alu_res;

    iter_mul #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_iter_mul (
        .clk     (clk),
        .rst_n   (reset_n),
        .start   (mul_start_c),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done_c  (mul_done_c),
        .product (mul_product)
    );

    // MUL sequencing and EX/MEM next values
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_res;
        wdata_d   = fwd_b;
        rd_d      = ID_EX_rd;
        ctrl_d    = id_ctrl;
        case (state_q)
            IDLE: begin
                if (ID_EX_alu_op == ALU_OP_MUL) begin
                    alu_out_d = '0;
                    wdata_d   = '0;
                    rd_d      = '0;
                    ctrl_d    = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                alu_out_d = '0;
                wdata_d   = '0;
                rd_d      = '0;
                ctrl_d    = '0;
                // !mul_busy guards against ever stranding the FSM in RUN
                if (mul_done_c || !mul_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // alu_op is still MUL here; it is deliberately not looked at
                alu_out_d = mul_product;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign EX_MEM_alu_out    = alu_out_q;
    assign EX_MEM_write_data = wdata_q;
    assign EX_MEM_rd         = rd_q;
    assign EX_MEM_mem_read   = ctrl_q.mem_read;
    assign EX_MEM_mem_write  = ctrl_q.mem_write;
    assign EX_MEM_mem_to_reg = ctrl_q.mem_to_reg;
    assign EX_MEM_reg_write  = ctrl_q.reg_write;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected EX/MEM
// writes, a monitor pops them whenever EX/MEM carries a write or store.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ID_EX_data1, ID_EX_data2, ID_EX_imm_gen, wb_data;
    logic [4:0]  ID_EX_rd;
    logic [3:0]  ID_EX_inst_func;
    logic [1:0]  ID_EX_alu_op, forward_a, forward_b;
    logic        ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write;
    logic        ID_EX_mem_to_reg, ID_EX_reg_write;
    logic [31:0] alu_out, EX_MEM_alu_out, EX_MEM_write_data;
    logic        ex_busy;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg, EX_MEM_reg_write;

    // Second instance (MUL_BITS=4) with its own alu_op / reg_write
    logic [1:0]  alu_op4;
    logic        reg_write4;
    logic [31:0] alu_out4, ex_mem_alu_out4, ex_mem_wdata4;
    logic        ex_busy4;
    logic [4:0]  ex_mem_rd4;
    logic        ex_mem_mr4, ex_mem_mw4, ex_mem_m2r4, ex_mem_rw4;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .MUL_BITS(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .ID_EX_data1(ID_EX_data1), .ID_EX_data2(ID_EX_data2), .ID_EX_imm_gen(ID_EX_imm_gen),
        .ID_EX_rd(ID_EX_rd), .ID_EX_inst_func(ID_EX_inst_func), .ID_EX_alu_op(ID_EX_alu_op),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_mem_read(ID_EX_mem_read),
        .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
        .ID_EX_reg_write(ID_EX_reg_write), .forward_a(forward_a), .forward_b(forward_b),
        .wb_data(wb_data), .alu_out(alu_out), .ex_busy(ex_busy),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_write_data(EX_MEM_write_data),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read),
        .EX_MEM_mem_write(EX_MEM_mem_write), .EX_MEM_mem_to_reg(EX_MEM_mem_to_reg),
        .EX_MEM_reg_write(EX_MEM_reg_write)
    );

    execute_stage #(.XLEN(32), .MUL_BITS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .ID_EX_data1(ID_EX_data1), .ID_EX_data2(ID_EX_data2), .ID_EX_imm_gen(ID_EX_imm_gen),
        .ID_EX_rd(ID_EX_rd), .ID_EX_inst_func(ID_EX_inst_func), .ID_EX_alu_op(alu_op4),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_mem_read(1'b0),
        .ID_EX_mem_write(1'b0), .ID_EX_mem_to_reg(1'b0),
        .ID_EX_reg_write(reg_write4), .forward_a(forward_a), .forward_b(forward_b),
        .wb_data(wb_data), .alu_out(alu_out4), .ex_busy(ex_busy4),
        .EX_MEM_alu_out(ex_mem_alu_out4), .EX_MEM_write_data(ex_mem_wdata4),
        .EX_MEM_rd(ex_mem_rd4), .EX_MEM_mem_read(ex_mem_mr4),
        .EX_MEM_mem_write(ex_mem_mw4), .EX_MEM_mem_to_reg(ex_mem_m2r4),
        .EX_MEM_reg_write(ex_mem_rw4)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    task automatic push(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        exp_t e;
        e.alu = alu;
        e.wd  = wd;
        e.rd  = rd;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] func,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic src, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] wb, input logic [4:0] rd,
                         input logic mw, input logic rw);
        ID_EX_alu_op     = op;
        ID_EX_inst_func  = func;
        ID_EX_data1      = d1;
        ID_EX_data2      = d2;
        ID_EX_imm_gen    = imm;
        ID_EX_alu_src    = src;
        forward_a        = fa;
        forward_b        = fb;
        wb_data          = wb;
        ID_EX_rd         = rd;
        ID_EX_mem_read   = 1'b0;
        ID_EX_mem_write  = mw;
        ID_EX_mem_to_reg = 1'b0;
        ID_EX_reg_write  = rw;
    endtask

    task automatic nop();
        drive(2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    // One driven op per cycle, expected EX/MEM write queued
    task automatic alu_vec(input logic [1:0] op, input logic [3:0] func,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic src, input logic [4:0] rd, input logic [31:0] exp);
        drive(op, func, d1, d2, imm, src, 2'b00, 2'b00, 32'h0, rd, 1'b0, 1'b1);
        push(exp, d2, rd);
        @(negedge clk);
    endtask

    // Runs one MUL on u_dut; returns at the negedge after the result edge
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp);
        int busy_cnt;
        logic bubble_bad;
        drive(2'b11, 4'h0, a, b, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, rd, 1'b0, 1'b1);
        push(exp, b, rd);
        busy_cnt   = 0;
        bubble_bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!ex_busy) break;
            busy_cnt++;
            if (i > 0 && (EX_MEM_reg_write || EX_MEM_mem_write || EX_MEM_mem_read ||
                          EX_MEM_mem_to_reg || EX_MEM_alu_out != 32'h0 || EX_MEM_rd != 5'd0))
                bubble_bad = 1'b1;
            // operand changes after capture must not affect the product
            if (i == 5) ID_EX_data1 = ~a;
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        check("mul_bubble", 32'(bubble_bad), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: every EX/MEM write or store must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && (EX_MEM_reg_write || EX_MEM_mem_write)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ex_mem_write", EX_MEM_alu_out, 32'hxxxxxxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("ex_mem_alu_out", EX_MEM_alu_out, e.alu);
                    check("ex_mem_write_data", EX_MEM_write_data, e.wd);
                    check("ex_mem_rd", 32'(EX_MEM_rd), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int busy4;
        alu_op4    = 2'b00;
        reg_write4 = 1'b0;
        nop();
        reset_n = 1'b0;

        // Reset: EX/MEM clear, ex_busy follows alu_op
        ID_EX_alu_op = 2'b11;
        #1 check("reset_busy_mul", 32'(ex_busy), 32'd1);
        ID_EX_alu_op = 2'b00;
        #1 check("reset_busy_idle", 32'(ex_busy), 32'd0);
        check("reset_alu_out", EX_MEM_alu_out, 32'h0);
        check("reset_ctrl", {28'h0, EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg,
                             EX_MEM_reg_write}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU vectors
        alu_vec(2'b10, 4'b0000, 32'd5, 32'd7, 32'h0, 1'b0, 5'd1, 32'd12);
        alu_vec(2'b10, 4'b1000, 32'd5, 32'd7, 32'h0, 1'b0, 5'd2, 32'hFFFFFFFE);
        alu_vec(2'b10, 4'b1101, 32'h80000000, 32'd7, 32'd4, 1'b1, 5'd3, 32'hF8000000);
        alu_vec(2'b10, 4'b0101, 32'h80000000, 32'd7, 32'd4, 1'b1, 5'd4, 32'h08000000);
        alu_vec(2'b10, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 5'd5, 32'd1);
        alu_vec(2'b10, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 5'd6, 32'd0);
        alu_vec(2'b01, 4'b0000, 32'd9, 32'd10, 32'h0, 1'b0, 5'd7, 32'hFFFFFFFF);
        alu_vec(2'b00, 4'b0000, 32'd8, 32'd8, 32'h0, 1'b0, 5'd8, 32'h10);

        // Forwarding: A from EX/MEM (0x10), B from writeback (3), as a store
        drive(2'b00, 4'h0, 32'hAAAA, 32'hBBBB, 32'h0, 1'b0, 2'b01, 2'b10, 32'h3, 5'd9, 1'b1, 1'b0);
        push(32'h13, 32'h3, 5'd9);
        #1 check("alu_out_comb_fwd", alu_out, 32'h13);
        @(negedge clk);
        // Select 2'b11 behaves as 2'b00
        drive(2'b00, 4'h0, 32'h20, 32'h1, 32'h0, 1'b0, 2'b11, 2'b11, 32'h5, 5'd10, 1'b0, 1'b1);
        push(32'h21, 32'h1, 5'd10);
        @(negedge clk);
        nop();
        @(negedge clk);

        // MUL, then back-to-back MULs
        run_mul(32'h0000FFFF, 32'h00010001, 5'd11, 32'hFFFFFFFF);
        nop();
        @(negedge clk);
        run_mul(32'hFFFFFFFD, 32'd7, 5'd12, 32'hFFFFFFEB);
        run_mul(32'd6, 32'd6, 5'd13, 32'd36);
        nop();
        repeat (3) @(negedge clk);

        // Reset in the middle of a MUL; no result expected
        drive(2'b11, 4'h0, 32'h1234, 32'h5678, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 5'd14, 1'b0, 1'b1);
        repeat (11) @(negedge clk);
        #1 check("midrun_busy", 32'(ex_busy), 32'd1);
        reset_n = 1'b0;
        #1 check("midrun_reset_alu_out", EX_MEM_alu_out, 32'h0);
        check("midrun_reset_busy_mul", 32'(ex_busy), 32'd1);
        ID_EX_alu_op = 2'b00;
        #1 check("midrun_reset_busy_idle", 32'(ex_busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(2'b00, 4'h0, 32'd1, 32'd2, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 5'd15, 1'b0, 1'b1);
        push(32'd3, 32'd2, 5'd15);
        @(negedge clk);
        #1 check("post_reset_add", EX_MEM_alu_out, 32'd3);
        check("post_reset_busy", 32'(ex_busy), 32'd0);
        nop();
        @(negedge clk);

        // MUL_BITS=4 instance: 9 busy cycles, result at the following edge
        ID_EX_data1 = 32'h0000FFFF;
        ID_EX_data2 = 32'h00010001;
        ID_EX_rd    = 5'd16;
        alu_op4     = 2'b11;
        reg_write4  = 1'b1;
        busy4       = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!ex_busy4) break;
            busy4++;
            @(negedge clk);
        end
        check("mul4_busy_cycles", 32'(busy4), 32'd9);
        @(negedge clk);
        #1 check("mul4_result", ex_mem_alu_out4, 32'hFFFFFFFF);
        check("mul4_reg_write", 32'(ex_mem_rw4), 32'd1);
        alu_op4    = 2'b00;
        reg_write4 = 1'b0;
        nop();
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the RISC-V pipeline. It is the reader end of the ID/EX pipeline register and the writer of the EX/MEM register.
- Applies operand forwarding, decodes the ALU operation from alu_op and inst_func, and computes the result.
- Supports a multi-cycle iterative MUL. During MUL it raises ex_busy so the hazard unit freezes PC, IF/ID and ID/EX.
- Exports the combinational ALU result (alu_out) for ID-stage branch forwarding.

Parameters:
- XLEN, 32, datapath width.
- MUL_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8. MUL_CYC = XLEN/MUL_BITS.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset
- ID_EX_data1  input  XLEN  rs1 value
- ID_EX_data2  input  XLEN  rs2 value
- ID_EX_imm_gen  input  XLEN  sign-extended immediate
- ID_EX_rd  input  5  destination register
- ID_EX_inst_func  input  4  {inst[30], funct3}
- ID_EX_alu_op  input  2  00 add, 01 sub, 10 funct decode, 11 mul
- ID_EX_alu_src  input  1  1 = operand B is the immediate
- ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_reg_write  input  1 each  control bits
- forward_a  input  2  operand A select: 00 ID_EX_data1, 01 EX_MEM_alu_out, 10 wb_data, 11 = 00
- forward_b  input  2  same encoding, applied to rs2 before the alu_src mux
- wb_data  input  XLEN  MEM/WB writeback value
- alu_out  output  XLEN  combinational result of the non-MUL path
- ex_busy  output  1  stall request to the hazard unit
- EX_MEM_alu_out  output  XLEN  registered result
- EX_MEM_write_data  output  XLEN  forwarded rs2, used as store data
- EX_MEM_rd  output  5  registered destination register
- EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg, EX_MEM_reg_write  output  1 each  registered control bits

Interface decision: one clock (clk); reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset: all EX_MEM_* outputs are 0 and FSM = IDLE. ex_busy follows its equation, so it is 1 during reset only if ID_EX_alu_op = 11.
- Operands:
  - opA = fwd(forward_a).
  - fwdB = fwd(forward_b).
  - opB = ID_EX_alu_src ? ID_EX_imm_gen : fwdB.
- ALU, alu_op = 10, by funct3:
  - 000: sub if inst_func[3] and !alu_src, else add.
  - 001: SLL. 010: SLT (signed). 011: SLTU.
  - 100: XOR.
  - 101: SRA if inst_func[3], else SRL.
  - 110: OR. 111: AND.
  - Shift amount = opB[4:0]. Add/sub wrap modulo 2^XLEN.
- ALU, alu_op = 00: add. alu_op = 01: sub.
- Non-MUL path latency: 1 cycle. EX/MEM loads every cycle unless the FSM dictates otherwise.
- MUL result: low XLEN bits of opA*opB, unsigned shift-add. The low half is identical for signed operands.
- FSM states IDLE, RUN, DONE:
  - IDLE with alu_op ≠ 11: normal operation.
  - IDLE with alu_op = 11:
    - ex_busy = 1 (combinational, same cycle).
    - Capture opA and opB into mcand/mplier, clear acc, cnt = 0.
    - EX/MEM loads a bubble: all control bits 0, data 0.
    - Next state RUN.
  - RUN:
    - ex_busy = 1.
    - Each cycle: acc += mcand * mplier[MUL_BITS-1:0]; mcand <<= MUL_BITS; mplier >>= MUL_BITS; cnt++.
    - EX/MEM holds the bubble.
    - When cnt = MUL_CYC-1, next state DONE.
  - DONE:
    - ex_busy = 0.
    - EX/MEM loads acc, EX_MEM_rd and the ID_EX control bits.
    - alu_op is ignored in this state, so the same MUL is not restarted.
    - Next state IDLE.
- ex_busy = (state==IDLE && ID_EX_alu_op==11) || state==RUN.
- MUL total occupancy: MUL_CYC+2 cycles; the result is in EX/MEM at edge MUL_CYC+2.
- Forwarding inputs are sampled only in the IDLE capture cycle. Changes during RUN/DONE have no effect on the product.
- Back-to-back MULs: DONE → IDLE. The second MUL enters IDLE next cycle and restarts normally.
- Reset mid-MUL: immediate return to IDLE; EX/MEM cleared; the partial product is discarded.
- alu_out during RUN/DONE: reflects the non-MUL path on the current operands; it is not valid for forwarding.

Decomposition:
- Shared package riscv_pkg:
  - ALU_OP_* constants (2 bits).
  - FWD_* select constants.
  - funct3 constants.
  - ex_state_e enum {IDLE, RUN, DONE}.
- Sub-module iter_mul (parameters XLEN, MUL_BITS): start/busy/done handshake; contains acc, mcand, mplier and cnt.
- The ALU decode stays inline.

Test Plan:
- alu_op=10, func=0000, data1=5, data2=7, fwd=00 → EX_MEM_alu_out=12 after 1 clk. Same with func=1000 → 0xFFFFFFFE.
- func=1101, data1=0x80000000, imm=4, alu_src=1 → 0xF8000000. func=0101 → 0x08000000. func=0010 on -1 vs 1 → 1; func=0011 → 0.
- forward_a=01 with previous result 0x10; forward_b=10 with wb_data=0x3 → 0x13. Store case: EX_MEM_write_data=0x3.
- alu_op=11, 0x0000FFFF * 0x00010001, MUL_BITS=1:
  - ex_busy high for 33 cycles; bubble in EX/MEM during that time.
  - At edge 34: EX_MEM_alu_out=0xFFFFFFFF and reg_write=1.
  - Repeat with MUL_BITS=4: busy for 9 cycles.
- Two consecutive MULs: (-3)*7 → 0xFFFFFFEB, then 6*6 → 36. Exactly two results written, no duplicate.
- reset_n low at RUN cycle 10 → EX_MEM_* = 0, FSM in IDLE, ex_busy = 0 once alu_op≠11. After release, a new add completes in 1 cycle.
